// File: rtl/axis_frame_store_px.sv
// Store-and-forward AXI-Stream frame buffer: captures one frame into on-chip RAM,
// then replays it with a per-lane point operation applied on the read path.

module axis_frame_store_px_lane #(
    parameter int PIX_W = 8
) (
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] param,
    input  logic [PIX_W-1:0] p,
    output logic [PIX_W-1:0] q
);
    localparam logic [PIX_W-1:0] PMAX = '1;

    // Two guard bits: MSB flags a negative result, the next one flags overflow.
    logic [PIX_W+1:0] sum;

    always_comb begin
        sum = {2'b00, p} + {{2{param[PIX_W-1]}}, param};
        q   = p;
        case (mode)
            2'd1: q = PMAX - p;
            2'd2: begin
                if (sum[PIX_W+1])    q = '0;
                else if (sum[PIX_W]) q = PMAX;
                else                 q = sum[PIX_W-1:0];
            end
            2'd3: q = (p >= param) ? PMAX : '0;
            default: q = p;
        endcase
    end
endmodule

module axis_frame_store_px #(
    parameter int  PIX_W  = 8,
    parameter int  LANES  = 4,
    parameter int  DEPTH  = 576,
    localparam int DATA_W = PIX_W * LANES,
    localparam int AW     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            cfg_mode,
    input  logic [PIX_W-1:0]      cfg_param,
    input  logic [AW-1:0]         cfg_frame_len,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tstrb,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tstrb,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_len
);
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_FILL  = 2'd1;
    localparam logic [1:0]    S_DRAIN = 2'd2;
    localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

    logic [1:0]                    state;
    logic [AW-1:0]                 wcnt, rptr, len_q, len_c, wcnt_inc, waddr;
    logic [1:0]                    mode_q;
    logic [PIX_W-1:0]              param_q;
    logic                          err_q;
    logic                          s_hs, full, rd_en, adv, out_vld, last_q;
    logic [DATA_W-1:0]             ram [DEPTH];
    logic [LANES-1:0][PIX_W-1:0]   rd_q, op_d;
    logic                          unused_tstrb;

    assign unused_tstrb = ^s_axis_tstrb;

    assign len_c    = (cfg_frame_len == '0 || cfg_frame_len > DEPTH_L) ? DEPTH_L : cfg_frame_len;
    assign s_hs     = s_axis_tvalid && s_axis_tready;
    assign wcnt_inc = wcnt + 1'b1;
    assign full     = (wcnt_inc == len_q);
    assign waddr    = (state == S_IDLE) ? '0 : wcnt;

    // Output register advances when empty or being consumed; reads prefetch into it.
    assign adv   = !out_vld || m_axis_tready;
    assign rd_en = (state == S_DRAIN) && (rptr != len_q) && adv;

    assign s_axis_tready = (state != S_DRAIN);
    assign busy          = (state != S_IDLE);
    assign err_len       = err_q;
    assign m_axis_tvalid = out_vld;
    assign m_axis_tlast  = last_q;
    assign m_axis_tstrb  = '1;
    assign m_axis_tdata  = out_vld ? op_d : '0;
    assign frame_done    = out_vld && m_axis_tready && last_q;

    always_ff @(posedge clk) begin
        if (s_hs) ram[waddr] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_q <= ram[rptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            rptr    <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            param_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_hs) begin
                        mode_q  <= cfg_mode;
                        param_q <= cfg_param;
                        rptr    <= '0;
                        wcnt    <= AW'(1);
                        if (s_axis_tlast || len_c == AW'(1)) begin
                            state <= S_DRAIN;
                            len_q <= AW'(1);
                            err_q <= s_axis_tlast != (len_c == AW'(1));
                        end else begin
                            state <= S_FILL;
                            len_q <= len_c;
                            err_q <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (s_hs) begin
                        wcnt <= wcnt_inc;
                        // Early tlast shrinks the frame; a missing tlast at len is also flagged.
                        if (s_axis_tlast || full) begin
                            state <= S_DRAIN;
                            len_q <= wcnt_inc;
                            err_q <= s_axis_tlast != full;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rd_en)      rptr  <= rptr + 1'b1;
                    if (frame_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld <= 1'b0;
            last_q  <= 1'b0;
        end else if (adv) begin
            out_vld <= rd_en;
            last_q  <= rd_en && (rptr == len_q - 1'b1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        axis_frame_store_px_lane #(.PIX_W(PIX_W)) u_lane (
            .mode  (mode_q),
            .param (param_q),
            .p     (rd_q[i]),
            .q     (op_d[i])
        );
    end
endmodule

// File: tb/tb_axis_frame_store_px.sv
// Directed bench for axis_frame_store_px: scoreboard of expected output beats
// filled as input beats are driven, drained by a monitor on the output stream.

module tb_axis_frame_store_px;
    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 576;
    localparam int DW    = PIX_W * LANES;
    localparam int AW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rstn;
    logic [1:0]      cfg_mode;
    logic [7:0]      cfg_param;
    logic [AW-1:0]   cfg_frame_len;
    logic [DW-1:0]   s_tdata;
    logic [DW/8-1:0] s_tstrb;
    logic            s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tstrb;
    logic            m_tlast, m_tvalid, m_tready;
    logic            busy, frame_done, err_len;

    logic rand_ready = 1'b0;
    logic rnd_bit    = 1'b1;

    always #5 clk = ~clk;
    assign m_tready = rand_ready ? rnd_bit : 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    axis_frame_store_px #(.PIX_W(PIX_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_mode      (cfg_mode),
        .cfg_param     (cfg_param),
        .cfg_frame_len (cfg_frame_len),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_len       (err_len)
    );

    int nasserts = 0;
    int nfail    = 0;
    int ob       = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [32:0] sb[$];
    logic [31:0] txd[$];
    logic [31:0] expd[$];
    logic        stall_prev = 1'b0;
    logic [32:0] prev_beat  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_op(input logic [1:0] m, input logic [7:0] prm,
                                          input logic [31:0] d);
        logic [31:0] r;
        int p, o, v;
        r = '0;
        o = (prm > 8'd127) ? int'(prm) - 256 : int'(prm);
        for (int i = 0; i < 4; i++) begin
            p = int'(d[8*i +: 8]);
            case (m)
                2'd0: v = p;
                2'd1: v = 255 - p;
                2'd2: begin
                    v = p + o;
                    if (v < 0)   v = 0;
                    if (v > 255) v = 255;
                end
                default: v = (p >= int'(prm)) ? 255 : 0;
            endcase
            r[8*i +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic void fill_model(input logic [1:0] m, input logic [7:0] prm);
        expd.delete();
        foreach (txd[i]) expd.push_back(exp_op(m, prm, txd[i]));
    endfunction

    function automatic void fill_ramp(input int n);
        txd.delete();
        for (int b = 0; b < n; b++)
            txd.push_back({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)});
    endfunction

    function automatic void fill_rand(input int n);
        txd.delete();
        for (int b = 0; b < n; b++) txd.push_back($urandom);
    endfunction

    // Output monitor: scoreboard pop on handshake, AXIS hold check while stalled.
    always @(negedge clk) begin
        if (rstn) begin
            if (stall_prev)
                chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
            if (m_tvalid && m_tready) begin
                chk("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) chk("out_beat", {m_tlast, m_tdata}, sb.pop_front());
                ob++;
            end
            if (frame_done) done_cnt++;
            stall_prev = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        int t = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!s_tready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) chk("in_ready_timeout", t < 2000, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input logic [AW-1:0] len, input logic [1:0] mode,
                             input logic [7:0] prm, input int tlast_idx, input logic exp_err);
        int t = 0;
        cfg_frame_len = len;
        cfg_mode      = mode;
        cfg_param     = prm;
        for (int b = 0; b < txd.size(); b++) begin
            if (b < expd.size()) sb.push_back({b == expd.size() - 1, expd[b]});
            send_beat(txd[b], b == tlast_idx);
            if (b == 0) begin
                // Config changes mid-frame must not reach the output.
                cfg_mode  = mode + 2'd1;
                cfg_param = ~prm;
                if (expd.size() > 1) chk("err_cleared", err_len, 0);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("drain_ready_low", s_tready, 0);
        chk("out_not_yet", m_tvalid, 0);
        @(posedge clk); #1;
        chk("out_latency", m_tvalid, 1);
        while ((sb.size() != 0 || busy) && t < 5000) begin
            @(posedge clk); #3;
            t++;
        end
        chk("drain_timeout", t < 5000, 1);
        exp_done++;
        chk("frame_done_cnt", done_cnt, exp_done);
        chk("err_len", err_len, exp_err);
        chk("idle_ready", s_tready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int ob0;
        rstn          = 1'b0;
        cfg_mode      = 2'd0;
        cfg_param     = '0;
        cfg_frame_len = '0;
        s_tdata       = '0;
        s_tstrb       = '0;
        s_tlast       = 1'b0;
        s_tvalid      = 1'b0;
        #3;
        chk("rst_s_tready", s_tready, 1);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast",  m_tlast, 0);
        chk("rst_m_tdata",  m_tdata, 0);
        chk("rst_m_tstrb",  m_tstrb, 4'hF);
        chk("rst_busy",     busy, 0);
        chk("rst_done",     frame_done, 0);
        chk("rst_err",      err_len, 0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // Full-depth ramp, pass-through
        fill_ramp(576); fill_model(2'd0, 8'h00);
        run_frame(AW'(576), 2'd0, 8'h00, 575, 1'b0);

        // Early tlast: 100 stored beats, error flagged
        fill_ramp(100); fill_model(2'd1, 8'h00);
        run_frame(AW'(576), 2'd1, 8'h00, 99, 1'b1);

        // Invert, single-beat frame (len 1 with tlast), clears previous error
        txd = '{32'h00FF7F80};
        expd = '{32'hFF00807F};
        run_frame(AW'(1), 2'd1, 8'h00, 0, 1'b0);

        // Threshold
        txd = '{32'h00FF7F80, 32'h00000000};
        expd = '{32'h00FF00FF, 32'h00000000};
        run_frame(AW'(2), 2'd3, 8'h80, 1, 1'b0);

        // Saturating add, positive offset; len 0 means full depth so tlast is early
        txd = '{32'hF8F00005};
        expd = '{32'hFFFF1015};
        run_frame(AW'(0), 2'd2, 8'h10, 0, 1'b1);

        // Saturating add, negative offset
        txd = '{32'h0A20FF10, 32'hF8F00005};
        expd = '{32'h0010EF00, 32'hE8E00000};
        run_frame(AW'(2), 2'd2, 8'hF0, 1, 1'b0);

        // Length reached without tlast
        fill_rand(4); fill_model(2'd3, 8'h40);
        run_frame(AW'(4), 2'd3, 8'h40, -1, 1'b1);

        // Random backpressure during drain
        rand_ready = 1'b1;
        fill_rand(64); fill_model(2'd2, 8'hC7);
        run_frame(AW'(64), 2'd2, 8'hC7, 63, 1'b0);
        rand_ready = 1'b0;

        // Reset in the middle of drain
        fill_ramp(576); fill_model(2'd0, 8'h00);
        cfg_frame_len = '0;
        cfg_mode      = 2'd0;
        cfg_param     = 8'h00;
        for (int b = 0; b < 576; b++) begin
            sb.push_back({b == 575, expd[b]});
            send_beat(txd[b], b == 575);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        ob0 = ob;
        t = 0;
        while (ob < ob0 + 300 && t < 5000) begin
            @(posedge clk); #3;
            t++;
        end
        chk("mid_drain_timeout", t < 5000, 1);
        rstn = 1'b0;
        #1;
        chk("mr_s_tready", s_tready, 1);
        chk("mr_m_tvalid", m_tvalid, 0);
        chk("mr_m_tlast",  m_tlast, 0);
        chk("mr_m_tdata",  m_tdata, 0);
        chk("mr_busy",     busy, 0);
        chk("mr_done",     frame_done, 0);
        chk("mr_err",      err_len, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        fill_rand(576); fill_model(2'd0, 8'h00);
        run_frame(AW'(0), 2'd0, 8'h00, 575, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end
endmodule
